bus_select_arbiter: RTL and testbench

Parametrised, registered successor to the flat 32-to-5 bus-source encoder. Takes N request lines from register/unit output-enable logic and grants the shared bus to exactly one of them. Emits a one-hot grant, a binary select code and status flags. Holds ownership across cycles, supports fair round-robin hand-over, and flags illegal multi-drive requests. Sits between the control unit's output-enable signals and the bus multiplexer select input.

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_onehot_encoder.sv | 20 ++
 rtl/bus_select_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_select_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus select arbiter.
package bus_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  localparam int MAX_N = 64;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/bus_onehot_encoder.sv
// One-hot to binary index encoder; an all-zero input yields IDLE_CODE.
module bus_onehot_encoder #(
  parameter int N         = 32,
  parameter int W         = $clog2(N),
  parameter int IDLE_CODE = 2**W - 1
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] code
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) code = code | W'(i);
    end
    if (onehot == '0) code = W'(IDLE_CODE);
  end

endmodule

// File: rtl/bus_select_arbiter.sv
// Registered N-way bus arbiter with ownership hold, optional hold limit and multi-drive flag.
// Define BUS_ARB_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module bus_select_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N         = 32,
  parameter int W         = $clog2(N),
  parameter int IDLE_CODE = 2**W - 1,
  parameter int MAX_HOLD  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         multi,
  output logic [W:0]   hold_cnt
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] grant_d;
  logic [W-1:0] code_d;
  logic [W:0]   hold_d;
  logic [N-1:0] others;
  logic [W-1:0] start_ptr;
  logic [W-1:0] win;
  logic         owner_req;
  logic         limit_hit;
  logic         new_grant;

  // First set bit of cand, scanning upward from start and wrapping at N-1.
  function automatic logic [W-1:0] pick(input logic [N-1:0] cand, input logic [W-1:0] start);
    logic [W-1:0] w;
    logic         found;
    int           idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!found && cand[idx]) begin
        w     = W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

`ifdef BUS_ARB_RR_EN
  logic [W-1:0] rr_ptr_q;
  assign start_ptr = rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset)          rr_ptr_q <= '0;
    else if (new_grant) rr_ptr_q <= (int'(win) == N - 1) ? '0 : win + 1'b1;
  end
`else
  assign start_ptr = '0;
`endif

  // The registered grant is the current owner's one-hot, so masking it out leaves the contenders.
  assign others    = req & ~grant;
  assign win       = pick(others, start_ptr);
  assign owner_req = |(req & grant);
  assign limit_hit = (MAX_HOLD != 0) && (int'(hold_cnt) == MAX_HOLD);
  assign valid     = (state_q == ARB_OWNED);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    hold_d    = hold_cnt;
    new_grant = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (others != '0) begin
          new_grant = 1'b1;
          state_d   = ARB_OWNED;
          hold_d    = (W+1)'(1);
        end
      end
      ARB_OWNED: begin
        if (owner_req && !limit_hit) begin
          if (hold_cnt != '1) hold_d = hold_cnt + 1'b1;
        end else if (others != '0) begin
          new_grant = 1'b1;
          hold_d    = (W+1)'(1);
        end else if (owner_req) begin
          hold_d = (W+1)'(1);
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          hold_d  = '0;
        end
      end
    endcase
    if (new_grant) grant_d = N'(1) << win;
  end

  bus_onehot_encoder #(
    .N         (N),
    .W         (W),
    .IDLE_CODE (IDLE_CODE)
  ) u_enc (
    .onehot (grant_d),
    .code   (code_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant    <= '0;
      code     <= W'(IDLE_CODE);
      multi    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      code     <= code_d;
      multi    <= popcount_gt1(MAX_N'(req));
      hold_cnt <= hold_d;
    end
  end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Self-checking bench for bus_select_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model (one unlimited-hold and one MAX_HOLD=3 instance).
module tb_bus_select_arbiter;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] req = '0;

  logic [31:0] grant0, grant1;
  logic [4:0]  code0, code1;
  logic        valid0, valid1, multi0, multi1;
  logic [5:0]  hold0, hold1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_select_arbiter #(.N(N), .MAX_HOLD(0)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant0), .code(code0),
    .valid(valid0), .multi(multi0), .hold_cnt(hold0)
  );

  bus_select_arbiter #(.N(N), .MAX_HOLD(3)) dut_h (
    .clk(clk), .reset(reset), .req(req), .grant(grant1), .code(code1),
    .valid(valid1), .multi(multi1), .hold_cnt(hold1)
  );

  logic [44:0] act0, act1;
  assign act0 = {grant0, code0, valid0, multi0, hold0};
  assign act1 = {grant1, code1, valid1, multi1, hold1};

  // Reference model state, index 0 = unlimited hold, index 1 = hold limit of 3.
  bit m_owned [2];
  int m_owner [2];
  int m_hold  [2];
  int m_rr    [2];
  bit m_multi [2];
  int m_limit [2] = '{0, 3};

  function automatic int search(input logic [31:0] cand, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  function automatic int start_of(input int m);
`ifdef BUS_ARB_RR_EN
    return m_rr[m];
`else
    return 0 * m;
`endif
  endfunction

  function automatic void model_step(input logic [31:0] r, input logic rst);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) ones += int'(r[i]);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_owned[m] = 0; m_owner[m] = 0; m_hold[m] = 0; m_rr[m] = 0; m_multi[m] = 0;
      end else begin
        m_multi[m] = (ones > 1);
        if (!m_owned[m]) begin
          if (r != 0) begin
            m_owner[m] = search(r, start_of(m));
            m_rr[m]    = (m_owner[m] + 1) % N;
            m_owned[m] = 1;
            m_hold[m]  = 1;
          end
        end else begin
          bit          mine, at_limit;
          logic [31:0] rest;
          mine     = r[m_owner[m]];
          at_limit = (m_limit[m] != 0) && (m_hold[m] == m_limit[m]);
          rest     = r & ~(32'd1 << m_owner[m]);
          if (mine && !at_limit) begin
            m_hold[m] = (m_hold[m] < 63) ? m_hold[m] + 1 : 63;
          end else if (rest != 0) begin
            m_owner[m] = search(rest, start_of(m));
            m_rr[m]    = (m_owner[m] + 1) % N;
            m_hold[m]  = 1;
          end else if (mine) begin
            m_hold[m] = 1;
          end else begin
            m_owned[m] = 0;
            m_hold[m]  = 0;
          end
        end
      end
    end
  endfunction

  function automatic logic [44:0] exp_vec(input int m);
    logic [31:0] g;
    logic [4:0]  c;
    g = m_owned[m] ? (32'd1 << m_owner[m]) : 32'd0;
    c = m_owned[m] ? 5'(m_owner[m]) : 5'd31;
    return {g, c, 1'(m_owned[m]), 1'(m_multi[m]), 6'(m_hold[m])};
  endfunction

  task automatic cycle(input logic [31:0] r, input logic rst);
    @(negedge clk);
    req   = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 7; c++) begin
      cycle(32'd0, c < 2);
      total++;
      if (act0 !== {32'd0, 5'd31, 1'b0, 1'b0, 6'd0}) begin
        bad++; $display("FAIL reset_idle c=%0d got=%h want=%h", c, act0, {32'd0, 5'd31, 8'd0});
      end
      total++;
      if (act1 !== exp_vec(1)) begin
        bad++; $display("FAIL reset_idle_h c=%0d got=%h want=%h", c, act1, exp_vec(1));
      end
    end
  endtask

  task automatic test_single();
    for (int c = 1; c <= 4; c++) begin
      cycle(32'h10, 1'b0);
      total++;
      if (code0 !== 5'd4 || grant0 !== 32'h10 || valid0 !== 1'b1 || hold0 !== 6'(c)) begin
        bad++; $display("FAIL single c=%0d code=%0d grant=%h valid=%b hold=%0d want code=4 hold=%0d",
                        c, code0, grant0, valid0, hold0, c);
      end
    end
    cycle(32'd0, 1'b0);
    total++;
    if (act0 !== exp_vec(0) || valid0 !== 1'b0) begin
      bad++; $display("FAIL single_drop got=%h want=%h", act0, exp_vec(0));
    end
  endtask

`ifdef BUS_ARB_RR_EN
  task automatic test_rr_handover();
    logic [31:0] seq [5] = '{32'h5, 32'h4, 32'h5, 32'h1, 32'h5};
    int          own [5] = '{0, 2, 2, 0, 0};
    bit          mul [5] = '{1, 0, 1, 0, 1};
    cycle(32'd0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle(seq[c], 1'b0);
      total++;
      if (code0 !== 5'(own[c]) || valid0 !== 1'b1 || multi0 !== mul[c]) begin
        bad++; $display("FAIL rr_handover c=%0d code=%0d valid=%b multi=%b want code=%0d multi=%b",
                        c, code0, valid0, multi0, own[c], mul[c]);
      end
    end
  endtask
`else
  task automatic test_fixed_prio();
    cycle(32'd0, 1'b1);
    cycle(32'h8000_0002, 1'b0);
    total++;
    if (code0 !== 5'd1 || valid0 !== 1'b1 || multi0 !== 1'b1) begin
      bad++; $display("FAIL fixed_first code=%0d valid=%b multi=%b want 1 1 1", code0, valid0, multi0);
    end
    cycle(32'h8000_0000, 1'b0);
    total++;
    if (code0 !== 5'd31 || valid0 !== 1'b1 || grant0 !== 32'h8000_0000) begin
      bad++; $display("FAIL fixed_src31 code=%0d valid=%b grant=%h want 31 1 80000000", code0, valid0, grant0);
    end
  endtask
`endif

  task automatic test_max_hold();
    cycle(32'd0, 1'b1);
    for (int c = 0; c < 9; c++) begin
      int want_own;
      want_own = (c / 3) % 2;
      cycle(32'h3, 1'b0);
      total++;
      if (code1 !== 5'(want_own) || hold1 !== 6'((c % 3) + 1) || valid1 !== 1'b1) begin
        bad++; $display("FAIL max_hold c=%0d code=%0d hold=%0d want code=%0d hold=%0d",
                        c, code1, hold1, want_own, (c % 3) + 1);
      end
      total++;
      if (act0 !== exp_vec(0)) begin
        bad++; $display("FAIL max_hold_unlim c=%0d got=%h want=%h", c, act0, exp_vec(0));
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(32'd0, 1'b1);
    for (int c = 0; c < 3; c++) cycle(32'h80, 1'b0);
    total++;
    if (code0 !== 5'd7 || valid0 !== 1'b1) begin
      bad++; $display("FAIL mid_owned code=%0d valid=%b want 7 1", code0, valid0);
    end
    cycle(32'h80, 1'b1);
    total++;
    if (act0 !== {32'd0, 5'd31, 1'b0, 1'b0, 6'd0} || act1 !== {32'd0, 5'd31, 1'b0, 1'b0, 6'd0}) begin
      bad++; $display("FAIL mid_reset got=%h/%h want=%h", act0, act1, {32'd0, 5'd31, 8'd0});
    end
    cycle(32'h204, 1'b0);
    total++;
    if (code0 !== 5'd2 || valid0 !== 1'b1 || hold0 !== 6'd1) begin
      bad++; $display("FAIL mid_first code=%0d valid=%b hold=%0d want 2 1 1", code0, valid0, hold0);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, prev;
    logic        rst;
    prev = '0;
    cycle(32'd0, 1'b1);
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 9))
        0:       r = '0;
        1, 2, 3: r = prev;
        4, 5:    r = 32'd1 << $urandom_range(0, 31);
        6, 7:    r = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        8:       r = $urandom;
        default: r = prev ^ (32'd1 << $urandom_range(0, 31));
      endcase
      rst  = ($urandom_range(0, 59) == 0);
      prev = r;
      cycle(r, rst);
      total++;
      if (act0 !== exp_vec(0)) begin
        bad++; $display("FAIL random c=%0d req=%h got=%h want=%h", c, r, act0, exp_vec(0));
      end
      total++;
      if (act1 !== exp_vec(1)) begin
        bad++; $display("FAIL random_h c=%0d req=%h got=%h want=%h", c, r, act1, exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef BUS_ARB_RR_EN
    test_rr_handover();
`else
    test_fixed_prio();
`endif
    test_max_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
